// File: rtl/microwave_timer_core.sv
// Microwave cook-time datapath: min:sec editing, 1 s countdown, pause/resume,
// clear, quick-add and a timed done-beep. All outputs are registered.
module microwave_timer_core #(
  parameter int unsigned CLK_DIV   = 100_000_000,
  parameter int unsigned MAX_MIN   = 99,
  parameter int unsigned QUICK_ADD = 30,
  parameter int unsigned BEEP_SEC  = 3,
  parameter int unsigned MIN_W     = $clog2(MAX_MIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic [1:0]       sel,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             quick_add,
  output logic [MIN_W-1:0] min,
  output logic [5:0]       sec,
  output logic [1:0]       state,
  output logic             finish,
  output logic             beep
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam int unsigned BC_W  = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
  localparam int unsigned MW1   = MIN_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BEEP_SEC - 1);
  localparam logic [MIN_W-1:0] MIN_TOP  = MIN_W'(MAX_MIN);
  localparam logic [5:0]       SEC_TOP  = 6'd59;
  localparam logic [6:0]       QA       = 7'(QUICK_ADD);

  logic [MIN_W-1:0] r_min;
  logic [5:0]       r_sec;
  logic [1:0]       r_state;
  logic             r_finish;
  logic             r_beep;
  logic [DIV_W-1:0] r_div;
  logic [BC_W-1:0]  r_bcnt;

  logic             w_tick;
  logic             w_nonzero;
  logic             w_dec_zero;
  logic             w_up;
  logic             w_down;
  logic             w_qcarry;
  logic [MIN_W-1:0] w_dec_min;
  logic [MIN_W-1:0] w_base_min;
  logic [MIN_W-1:0] w_q_min;
  logic [5:0]       w_dec_sec;
  logic [5:0]       w_base_sec;
  logic [5:0]       w_q_sec;
  logic [6:0]       w_qsum;
  logic [MW1-1:0]   w_qmin_ext;

  always_comb begin
    w_tick    = (r_div == DIV_LAST);
    w_nonzero = (r_min != '0) || (r_sec != '0);
    w_up      = btn_up & ~btn_down;
    w_down    = btn_down & ~btn_up;

    if (r_sec != '0) begin
      w_dec_min = r_min;
      w_dec_sec = r_sec - 6'd1;
    end else if (r_min != '0) begin
      w_dec_min = r_min - MIN_W'(1);
      w_dec_sec = SEC_TOP;
    end else begin
      w_dec_min = '0;
      w_dec_sec = '0;
    end
    w_dec_zero = (w_dec_min == '0) && (w_dec_sec == '0);

    // quick-add in RUN stacks on top of a same-edge tick decrement
    w_base_min = (r_state == S_RUN && w_tick) ? w_dec_min : r_min;
    w_base_sec = (r_state == S_RUN && w_tick) ? w_dec_sec : r_sec;
    w_qsum     = {1'b0, w_base_sec} + QA;
    w_qcarry   = (w_qsum >= 7'd60);
    w_qmin_ext = {1'b0, w_base_min} + {{MIN_W{1'b0}}, w_qcarry};
    if (w_qmin_ext > {1'b0, MIN_TOP}) begin
      w_q_min = MIN_TOP;
      w_q_sec = SEC_TOP;
    end else begin
      w_q_min = w_qmin_ext[MIN_W-1:0];
      w_q_sec = w_qcarry ? 6'(w_qsum - 7'd60) : w_qsum[5:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_min    <= '0;
      r_sec    <= '0;
      r_state  <= S_IDLE;
      r_finish <= 1'b0;
      r_beep   <= 1'b0;
      r_div    <= '0;
      r_bcnt   <= '0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clear) begin
            r_min <= '0;
            r_sec <= '0;
          end else if (start && w_nonzero) begin
            r_state <= S_RUN;
            r_div   <= '0;
          end else if (quick_add) begin
            r_min   <= w_q_min;
            r_sec   <= w_q_sec;
            r_state <= S_RUN;
            r_div   <= '0;
          end else if (sel == 2'b01) begin
            if (w_up)        r_sec <= (r_sec == SEC_TOP) ? '0 : r_sec + 6'd1;
            else if (w_down) r_sec <= (r_sec == '0) ? SEC_TOP : r_sec - 6'd1;
          end else if (sel == 2'b10) begin
            if (w_up)        r_min <= (r_min == MIN_TOP) ? '0 : r_min + MIN_W'(1);
            else if (w_down) r_min <= (r_min == '0) ? MIN_TOP : r_min - MIN_W'(1);
          end
        end
        S_RUN: begin
          if (clear) begin
            r_state <= S_IDLE;
            r_min   <= '0;
            r_sec   <= '0;
          end else if (pause) begin
            r_state <= S_PAUSE;
          end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (quick_add) begin
              r_min <= w_q_min;
              r_sec <= w_q_sec;
            end else if (w_tick) begin
              r_min <= w_dec_min;
              r_sec <= w_dec_sec;
              if (w_dec_zero) begin
                r_state  <= S_DONE;
                r_finish <= 1'b1;
                r_beep   <= 1'b1;
                r_bcnt   <= '0;
              end
            end
          end
        end
        S_PAUSE: begin
          if (clear) begin
            r_state <= S_IDLE;
            r_min   <= '0;
            r_sec   <= '0;
          end else if (start) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          if (clear) begin
            r_state <= S_IDLE;
            r_beep  <= 1'b0;
            r_bcnt  <= '0;
          end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
              if (r_bcnt == BC_LAST) begin
                r_state <= S_IDLE;
                r_beep  <= 1'b0;
                r_bcnt  <= '0;
              end else begin
                r_bcnt <= r_bcnt + BC_W'(1);
              end
            end
          end
        end
      endcase
    end
  end

  assign min    = r_min;
  assign sec    = r_sec;
  assign state  = r_state;
  assign finish = r_finish;
  assign beep   = r_beep;

endmodule

// File: tb/tb_microwave_timer_core.sv
// Bench for microwave_timer_core: directed scenarios plus a random run checked
// against a total-seconds reference model.
module tb_microwave_timer_core;
  localparam int CLK_DIV   = 10;
  localparam int MAX_MIN   = 99;
  localparam int QUICK_ADD = 30;
  localparam int BEEP_SEC  = 3;
  localparam int MIN_W     = $clog2(MAX_MIN + 1);
  localparam int MAXT      = MAX_MIN * 60 + 59;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic rst, btn_up, btn_down, start, pause, clear, quick_add;
  logic [1:0] sel;
  logic [MIN_W-1:0] min;
  logic [5:0] sec;
  logic [1:0] state;
  logic finish, beep;

  int checks = 0;
  int errors = 0;

  // model: cook time held as total seconds
  int m_t, m_st, m_ph, m_bc;
  logic m_fin, m_beep;

  microwave_timer_core #(
    .CLK_DIV(CLK_DIV), .MAX_MIN(MAX_MIN), .QUICK_ADD(QUICK_ADD), .BEEP_SEC(BEEP_SEC)
  ) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .sel(sel),
    .start(start), .pause(pause), .clear(clear), .quick_add(quick_add),
    .min(min), .sec(sec), .state(state), .finish(finish), .beep(beep)
  );

  always #5 clk = ~clk;

  function automatic int qadd(int t);
    return (t + QUICK_ADD > MAXT) ? MAXT : t + QUICK_ADD;
  endfunction

  task automatic model_step();
    bit tk;
    if (rst) begin
      m_t = 0; m_st = M_IDLE; m_ph = 0; m_bc = 0; m_fin = 0; m_beep = 0;
      return;
    end
    tk = (m_ph == CLK_DIV - 1);
    m_fin = 0;
    case (m_st)
      M_IDLE: begin
        if (clear) m_t = 0;
        else if (start && m_t != 0) begin m_st = M_RUN; m_ph = 0; end
        else if (quick_add) begin m_t = qadd(m_t); m_st = M_RUN; m_ph = 0; end
        else if (btn_up != btn_down) begin
          if (sel == 2'b01)
            m_t = (m_t / 60) * 60 + (btn_up ? (m_t % 60 + 1) % 60 : (m_t % 60 + 59) % 60);
          else if (sel == 2'b10)
            m_t = (btn_up ? (m_t / 60 + 1) % (MAX_MIN + 1)
                          : (m_t / 60 + MAX_MIN) % (MAX_MIN + 1)) * 60 + m_t % 60;
        end
      end
      M_RUN: begin
        if (clear) begin m_st = M_IDLE; m_t = 0; end
        else if (pause) m_st = M_PAUSE;
        else begin
          m_ph = (m_ph + 1) % CLK_DIV;
          if (tk) m_t = m_t - 1;
          if (quick_add) m_t = qadd(m_t);
          else if (tk && m_t == 0) begin m_st = M_DONE; m_fin = 1; m_beep = 1; m_bc = 0; end
        end
      end
      M_PAUSE: begin
        if (clear) begin m_st = M_IDLE; m_t = 0; end
        else if (start) m_st = M_RUN;
      end
      default: begin
        if (clear) begin m_st = M_IDLE; m_beep = 0; m_bc = 0; end
        else begin
          m_ph = (m_ph + 1) % CLK_DIV;
          if (tk) begin
            m_bc++;
            if (m_bc == BEEP_SEC) begin m_st = M_IDLE; m_beep = 0; m_bc = 0; end
          end
        end
      end
    endcase
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_time(int mm, int ss);
    clear = 1; step(); clear = 0;
    sel = 2'b10; btn_up = 1;
    for (int i = 0; i < mm; i++) step();
    sel = 2'b01;
    for (int i = 0; i < ss; i++) step();
    btn_up = 0; sel = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1; step(); step(); rst = 0;
    checks++;
    if ({min, sec, state, finish, beep} !== '0) begin
      errors++;
      $display("FAIL reset: got min=%0d sec=%0d st=%0d fin=%0b beep=%0b want all 0",
               min, sec, state, finish, beep);
    end
  endtask

  task automatic test_edit();
    sel = 2'b01; btn_down = 1; step(); btn_down = 0;
    checks++;
    if (sec !== 6'd59) begin errors++; $display("FAIL sec_down_wrap: got %0d want 59", sec); end
    btn_up = 1; step(); btn_up = 0;
    checks++;
    if (sec !== 6'd0) begin errors++; $display("FAIL sec_up_wrap: got %0d want 0", sec); end
    sel = 2'b10; btn_down = 1; step(); btn_down = 0;
    checks++;
    if (min !== 7'd99) begin errors++; $display("FAIL min_down_wrap: got %0d want 99", min); end
    btn_up = 1; btn_down = 1; step(); btn_up = 0; btn_down = 0;
    checks++;
    if (min !== 7'd99 || sec !== 6'd0 || state !== 2'b00) begin
      errors++; $display("FAIL both_btns: got %0d:%0d st=%0d want 99:0 st=0", min, sec, state);
    end
    btn_up = 1; step(); btn_up = 0; sel = 2'b00;
    checks++;
    if (min !== 7'd0) begin errors++; $display("FAIL min_up_wrap: got %0d want 0", min); end
  endtask

  task automatic test_countdown();
    int fin_cnt;
    set_time(0, 2);
    start = 1; step(); start = 0;
    checks++;
    if (state !== 2'b01) begin errors++; $display("FAIL cd_start: got st=%0d want 1", state); end
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 9) begin
        checks++;
        if (sec !== 6'd2) begin errors++; $display("FAIL cd_pre_tick: got %0d want 2", sec); end
      end
      if (k == 10) begin
        checks++;
        if (sec !== 6'd1 || state !== 2'b01) begin
          errors++; $display("FAIL cd_tick1: got sec=%0d st=%0d want 1,1", sec, state);
        end
      end
    end
    checks++;
    if ({min, sec} !== '0 || state !== 2'b11 || finish !== 1'b1 || beep !== 1'b1) begin
      errors++;
      $display("FAIL cd_done: got %0d:%0d st=%0d fin=%0b beep=%0b want 0:0 st=3 fin=1 beep=1",
               min, sec, state, finish, beep);
    end
    fin_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (finish === 1'b1) fin_cnt++;
      if (k == 29) begin
        checks++;
        if (state !== 2'b11 || beep !== 1'b1) begin
          errors++; $display("FAIL beep_hold: got st=%0d beep=%0b want 3,1", state, beep);
        end
      end
    end
    checks++;
    if (state !== 2'b00 || beep !== 1'b0) begin
      errors++; $display("FAIL beep_end: got st=%0d beep=%0b want 0,0", state, beep);
    end
    checks++;
    if (fin_cnt != 0) begin errors++; $display("FAIL finish_once: got %0d extra want 0", fin_cnt); end
  endtask

  task automatic test_pause();
    int bad;
    set_time(1, 0);
    start = 1; step(); start = 0;
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (min !== 7'd0 || sec !== 6'd59) begin
      errors++; $display("FAIL borrow: got %0d:%0d want 0:59", min, sec);
    end
    for (int k = 0; k < 4; k++) step();
    pause = 1; step(); pause = 0;
    checks++;
    if (state !== 2'b10) begin errors++; $display("FAIL pause_state: got %0d want 2", state); end
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (min !== 7'd0 || sec !== 6'd59 || state !== 2'b10) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pause_frozen: got %0d bad cycles want 0", bad); end
    start = 1; step(); start = 0;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if (sec !== 6'd59 || state !== 2'b01) begin
      errors++; $display("FAIL resume_early: got sec=%0d st=%0d want 59,1", sec, state);
    end
    step();
    checks++;
    if (sec !== 6'd58) begin errors++; $display("FAIL resume_tick: got %0d want 58", sec); end
  endtask

  task automatic test_quick_add();
    set_time(0, 0);
    start = 1; step(); start = 0;
    checks++;
    if (state !== 2'b00) begin errors++; $display("FAIL start_zero: got st=%0d want 0", state); end
    quick_add = 1; step(); quick_add = 0;
    checks++;
    if (min !== 7'd0 || sec !== 6'd30 || state !== 2'b01) begin
      errors++; $display("FAIL qa_idle: got %0d:%0d st=%0d want 0:30 st=1", min, sec, state);
    end
    set_time(0, 15);
    quick_add = 1; step();
    checks++;
    if (sec !== 6'd45 || state !== 2'b01) begin
      errors++; $display("FAIL qa_45: got %0d:%0d st=%0d want 0:45 st=1", min, sec, state);
    end
    step(); quick_add = 0;
    checks++;
    if (min !== 7'd1 || sec !== 6'd15) begin
      errors++; $display("FAIL qa_carry: got %0d:%0d want 1:15", min, sec);
    end
    set_time(99, 50);
    quick_add = 1; step(); quick_add = 0;
    checks++;
    if (min !== 7'd99 || sec !== 6'd59 || state !== 2'b01) begin
      errors++; $display("FAIL qa_sat: got %0d:%0d st=%0d want 99:59 st=1", min, sec, state);
    end
  endtask

  task automatic test_clear();
    set_time(0, 5);
    start = 1; step(); start = 0;
    step(); step(); step();
    clear = 1; pause = 1; step(); clear = 0; pause = 0;
    checks++;
    if (state !== 2'b00 || {min, sec} !== '0) begin
      errors++; $display("FAIL clear_pause: got %0d:%0d st=%0d want 0:0 st=0", min, sec, state);
    end
    set_time(0, 1);
    start = 1; step(); start = 0;
    for (int k = 0; k < 10; k++) step();
    checks++;
    if (state !== 2'b11) begin errors++; $display("FAIL reach_done: got st=%0d want 3", state); end
    step(); step(); step();
    clear = 1; step(); clear = 0;
    checks++;
    if (state !== 2'b00 || beep !== 1'b0) begin
      errors++; $display("FAIL clear_done: got st=%0d beep=%0b want 0,0", state, beep);
    end
  endtask

  task automatic test_reset_mid();
    set_time(0, 5);
    start = 1; step(); start = 0;
    for (int k = 0; k < 7; k++) step();
    rst = 1; step(); rst = 0;
    checks++;
    if ({min, sec, state, finish, beep} !== '0) begin
      errors++; $display("FAIL rst_run: got %0d:%0d st=%0d fin=%0b beep=%0b want all 0",
                         min, sec, state, finish, beep);
    end
    set_time(0, 1);
    start = 1; step(); start = 0;
    for (int k = 0; k < 12; k++) step();
    rst = 1; step(); rst = 0;
    checks++;
    if ({min, sec, state, finish, beep} !== '0) begin
      errors++; $display("FAIL rst_done: got %0d:%0d st=%0d fin=%0b beep=%0b want all 0",
                         min, sec, state, finish, beep);
    end
    quick_add = 1; step(); quick_add = 0;
    for (int k = 0; k < 9; k++) step();
    checks++;
    if (sec !== 6'd30) begin errors++; $display("FAIL rst_div_early: got %0d want 30", sec); end
    step();
    checks++;
    if (sec !== 6'd29) begin errors++; $display("FAIL rst_div_tick: got %0d want 29", sec); end
  endtask

  task automatic test_random();
    int r;
    set_time(0, 0);
    for (int cyc = 0; cyc < 5000; cyc++) begin
      {btn_up, btn_down, start, pause, clear, quick_add} = '0;
      rst = ($urandom_range(0, 1999) == 0);
      r = $urandom_range(0, 9);
      sel = (r < 6) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      btn_up   = ($urandom_range(0, 3) == 0);
      btn_down = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 999);
      if (r < 5) clear = 1;
      else if (r < 15) pause = !(m_st == M_RUN && m_ph == CLK_DIV - 1);
      else if (r < 65) start = 1;
      else if (r < 68) quick_add = 1;
      step();
      checks++;
      if (min !== MIN_W'(m_t / 60)) begin
        errors++; $display("FAIL rand_min cyc %0d: got %0d want %0d", cyc, min, m_t / 60);
      end
      checks++;
      if (sec !== 6'(m_t % 60)) begin
        errors++; $display("FAIL rand_sec cyc %0d: got %0d want %0d", cyc, sec, m_t % 60);
      end
      checks++;
      if (state !== 2'(m_st)) begin
        errors++; $display("FAIL rand_state cyc %0d: got %0d want %0d", cyc, state, m_st);
      end
      checks++;
      if (finish !== m_fin) begin
        errors++; $display("FAIL rand_finish cyc %0d: got %0b want %0b", cyc, finish, m_fin);
      end
      checks++;
      if (beep !== m_beep) begin
        errors++; $display("FAIL rand_beep cyc %0d: got %0b want %0b", cyc, beep, m_beep);
      end
    end
    {rst, btn_up, btn_down, start, pause, clear, quick_add} = '0;
    sel = 2'b00;
  endtask

  initial begin
    {rst, btn_up, btn_down, start, pause, clear, quick_add} = '0;
    sel = 2'b00;
    test_reset();
    test_edit();
    test_countdown();
    test_pause();
    test_quick_add();
    test_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/microwave_timer_core.md
Name: microwave_timer_core

Overview:
Parametrised successor to the microwave setting/countdown datapath. Holds a min:sec cook time, lets the user edit it, then counts it down once per second. Adds pause/resume, clear, a quick-add (+N s) key, a registered state code and a timed done-beep. Sits between the debounced button front-end and the FND display/buzzer drivers.

Parameters:
CLK_DIV, 100_000_000, clk cycles per 1 s tick; >= 2.
MAX_MIN, 99, maximum minute value; 1..255.
QUICK_ADD, 30, seconds added per quick_add pulse; 1..59.
BEEP_SEC, 3, seconds beep stays high in DONE; >= 1.
MIN_W, $clog2(MAX_MIN+1), derived minute width; not overridden.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
btn_up  in  1  single-cycle increment pulse
btn_down  in  1  single-cycle decrement pulse
sel  in  2  edit target: 01 = sec, 10 = min, 00/11 = none
start  in  1  pulse: start or resume
pause  in  1  pulse: pause while running
clear  in  1  pulse: abort and zero the time
quick_add  in  1  pulse: add QUICK_ADD s, start if idle
min  out  MIN_W  current minutes
sec  out  6  current seconds, 0..59
state  out  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
finish  out  1  one-cycle pulse on entry to DONE
beep  out  1  buzzer enable, high throughout DONE

Behaviour:
- Single clock. Reset is synchronous, active-high, sampled on the clk rising edge. All outputs are registered. Inputs take effect on the next edge, so latency is 1 cycle.
- Reset values: min=0, sec=0, state=IDLE, finish=0, beep=0, divider=0, beep counter=0.
- Command priority within one cycle: clear > pause > start > quick_add > btn_up/btn_down.
- Divider: counts 0..CLK_DIV-1 and advances only in RUN and DONE. A tick is the cycle in which divider==CLK_DIV-1; the divider wraps to 0 on that cycle. It is cleared to 0 on IDLE->RUN and held (not cleared) in PAUSE.
- IDLE:
  - Edits apply here only. With sel=01: up wraps sec 59->0, down wraps 0->59, with no carry into min. With sel=10: min wraps MAX_MIN<->0.
  - btn_up and btn_down together = no change. sel 00/11 = no change.
  - start with time != 0:00 -> RUN. start with 0:00 is ignored.
  - quick_add adds QUICK_ADD s (sec overflow past 59 carries into min, saturating at MAX_MIN:59) and goes to RUN in the same edge.
- RUN:
  - On tick: if sec>0 then sec-1. Else if min>0 then min-1 and sec=59.
  - A tick producing 0:00 moves to DONE on that same edge, with finish=1 for that one cycle.
  - pause -> PAUSE. clear -> IDLE with min=sec=0.
  - quick_add adds time (saturating as above) and stays in RUN. If it coincides with a tick, the tick decrement applies first, then the add. The result is non-zero, so there is no DONE.
  - btn_up/btn_down ignored.
- PAUSE: time and divider frozen. start -> RUN (divider resumes from its held count). clear -> IDLE zeroed. quick_add, btn_up and btn_down ignored.
- DONE:
  - beep=1. Time reads 0:00. The beep counter counts ticks; after BEEP_SEC ticks -> IDLE with beep=0.
  - clear -> IDLE immediately with beep=0. start, pause, quick_add and btn_* are ignored.
  - finish is never high in any cycle other than DONE entry.
- Any command that does not apply in the current state has no effect. rst mid-operation overrides everything.

Test Plan:
1. Reset, then with CLK_DIV=10, MAX_MIN=99: sel=01 and btn_down x1 -> sec=59. btn_up x1 -> sec=0. sel=10 and btn_down -> min=99. Assert btn_up and btn_down together -> no change. state stays 00.
2. Set 0:02, start -> state=01. Ticks every 10 cycles: 0:01, then 0:00 with state=11 and finish high exactly 1 cycle. beep high for 3 ticks (30 cycles), then state=00 and beep=0.
3. Set 1:00 and run -> first tick gives 0:59. Pause 4 cycles after a tick -> state=10 and values frozen for 50 cycles. start -> next tick arrives 6 cycles later.
4. From IDLE at 0:00, start -> ignored, state stays 00. quick_add -> 0:30 and state=01. At 0:45 in RUN, quick_add -> 1:15. At 99:50, quick_add -> 99:59 (saturated).
5. In RUN, assert clear and pause in the same cycle -> state=00 and time=0:00. In DONE, clear -> beep drops next cycle and state=00.
6. Assert rst mid-RUN and mid-DONE -> all outputs return to their reset values on the next edge, and the divider restarts from 0.
